// File: rtl/rd53_tx_frame_mux.sv
// rd53_tx_frame_mux: NUM_CH word streams, each with its own FIFO, round-robin
// merged onto one registered transceiver word bus. Cycles with no payload
// carry a comma idle word, and a K-character sync burst is inserted at a
// fixed period.

// Per-channel FIFO. When full, it drops the incoming word and flags it.
module rd53_tx_frame_mux_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic              wr_rdy,
  output logic              empty,
  output logic [DATA_W-1:0] rd_data,
  output logic              drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_en;

  // Ready comes from the registered count, so a full FIFO refuses a write
  // even in a cycle where it is popped.
  assign wr_rdy  = (count != CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = wr_vld & wr_rdy;
  assign drop    = wr_vld & ~wr_rdy;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2. The count is
  // unchanged on a simultaneous read and write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array. It has no reset because the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
endmodule

module rd53_tx_frame_mux #(
  parameter int                    DATA_W      = 16,
  parameter int                    NUM_CH      = 4,
  parameter int                    DEPTH       = 16,
  parameter int                    SYNC_PERIOD = 1024,
  parameter int                    SYNC_LEN    = 4,
  parameter logic [DATA_W-1:0]     IDLE_WORD   = 16'h00BC,
  parameter logic [DATA_W/8-1:0]   IDLE_K      = 2'b01,
  parameter logic [DATA_W-1:0]     SYNC_WORD   = 16'hBCBC,
  localparam int                   CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     out_en,
  output logic [DATA_W-1:0]        tx_data,
  output logic [DATA_W/8-1:0]      tx_charisk,
  output logic                     tx_valid,
  output logic [CH_W-1:0]          tx_ch,
  output logic [NUM_CH-1:0]        ovf,
  input  logic                     clr_ovf
);
  localparam int K_W  = DATA_W / 8;
  localparam int SC_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int BC_W = $clog2(SYNC_LEN) + 1;

  typedef enum logic [1:0] {INIT_SYNC, RUN, SYNC} state_t;

  state_t                         state, state_nxt;
  logic [SC_W-1:0]                sync_cnt, sync_nxt;
  logic [BC_W-1:0]                burst_cnt, burst_nxt;
  logic [CH_W-1:0]                last_grant, lg_nxt, gnt, ch_nxt;
  logic                           any_req, vld_nxt;
  logic [DATA_W-1:0]              data_nxt;
  logic [K_W-1:0]                 k_nxt;
  logic [NUM_CH-1:0]              empty, pop, drop;
  logic [NUM_CH-1:0][DATA_W-1:0]  head;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rd53_tx_frame_mux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_vld  (in_valid[c]),
      .wr_data (in_data[c*DATA_W +: DATA_W]),
      .rd_en   (pop[c]),
      .wr_rdy  (in_ready[c]),
      .empty   (empty[c]),
      .rd_data (head[c]),
      .drop    (drop[c])
    );
  end

  // Round-robin search. Pick the first non-empty channel after last_grant.
  always_comb begin
    int              idx_i;
    logic [CH_W-1:0] idx;
    any_req = 1'b0;
    gnt     = last_grant;
    idx_i   = 0;
    idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_i = (int'(last_grant) + i) % NUM_CH;
      idx   = CH_W'(idx_i);
      if (!any_req && !empty[idx]) begin
        any_req = 1'b1;
        gnt     = idx;
      end
    end
  end

  // Next state and next output word. When out_en is low, everything freezes
  // and the output is idle.
  always_comb begin
    state_nxt = state;
    sync_nxt  = sync_cnt;
    burst_nxt = burst_cnt;
    lg_nxt    = last_grant;
    ch_nxt    = tx_ch;
    pop       = '0;
    data_nxt  = IDLE_WORD;
    k_nxt     = IDLE_K;
    vld_nxt   = 1'b0;
    if (out_en) begin
      case (state)
        INIT_SYNC, SYNC: begin
          data_nxt = SYNC_WORD;
          k_nxt    = '1;
          if (burst_cnt == BC_W'(SYNC_LEN - 1)) begin
            state_nxt = RUN;
            burst_nxt = '0;
            sync_nxt  = '0;
          end else begin
            burst_nxt = burst_cnt + 1'b1;
          end
        end
        default: begin
          if (any_req) begin
            pop[gnt] = 1'b1;
            data_nxt = head[gnt];
            k_nxt    = '0;
            vld_nxt  = 1'b1;
            ch_nxt   = gnt;
            lg_nxt   = gnt;
          end
          if (sync_cnt == SC_W'(SYNC_PERIOD - 1)) begin
            state_nxt = SYNC;
            sync_nxt  = '0;
          end else begin
            sync_nxt = sync_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Registers for the state, the counters and the transmit word. A sticky
  // overflow set wins over clr_ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_SYNC;
      sync_cnt   <= '0;
      burst_cnt  <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      tx_data    <= IDLE_WORD;
      tx_charisk <= IDLE_K;
      tx_valid   <= 1'b0;
      tx_ch      <= '0;
      ovf        <= '0;
    end else begin
      state      <= state_nxt;
      sync_cnt   <= sync_nxt;
      burst_cnt  <= burst_nxt;
      last_grant <= lg_nxt;
      tx_data    <= data_nxt;
      tx_charisk <= k_nxt;
      tx_valid   <= vld_nxt;
      tx_ch      <= ch_nxt;
      ovf        <= (clr_ovf ? '0 : ovf) | drop;
    end
  end
endmodule

// File: tb/tb_rd53_tx_frame_mux.sv
// Scoreboard bench for rd53_tx_frame_mux. A queue-based reference model
// predicts every output cycle. The monitor compares each prediction on the
// falling edge after the clock edge it is tagged with.
module tb_rd53_tx_frame_mux;
  localparam int          DATA_W = 16, NUM_CH = 4, DEPTH = 16;
  localparam int          SYNC_PERIOD = 1024, SYNC_LEN = 4, CH_W = 2;
  localparam logic [15:0] IDLE_WORD = 16'h00BC, SYNC_WORD = 16'hBCBC;
  localparam logic [1:0]  IDLE_K = 2'b01;

  logic                     clk = 1'b0, rst_n = 1'b1;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0]        in_valid = '0, in_ready, ovf;
  logic                     out_en = 1'b0, clr_ovf = 1'b0;
  logic [DATA_W-1:0]        tx_data;
  logic [1:0]               tx_charisk;
  logic                     tx_valid;
  logic [CH_W-1:0]          tx_ch;

  rd53_tx_frame_mux dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_en(out_en), .tx_data(tx_data),
    .tx_charisk(tx_charisk), .tx_valid(tx_valid), .tx_ch(tx_ch),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [15:0] data;
    logic [1:0]  k;
    logic        v;
    logic [1:0]  ch;
    logic [3:0]  rdy;
    logic [3:0]  ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0, cyc_n = 0;
  bit          mon_on = 1'b0;

  // Reference model state: channel queues, the remaining burst words, the
  // RUN cycles since the last burst, the last grant, the last channel and the
  // overflow flags.
  logic [15:0] mq[NUM_CH][$];
  int          m_burst, m_run, m_lg, m_ch;
  logic [3:0]  m_ovf;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, req);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_burst = SYNC_LEN;
    m_run   = 0;
    m_lg    = NUM_CH - 1;
    m_ch    = 0;
    m_ovf   = '0;
  endtask

  // Predict the result of the next clock edge from the current inputs.
  task automatic model_step();
    exp_t e;
    bit   full[NUM_CH];
    int   c;
    for (int i = 0; i < NUM_CH; i++) full[i] = (mq[i].size() == DEPTH);
    e.tag = cyc_n + 1; e.data = IDLE_WORD; e.k = IDLE_K; e.v = 1'b0;
    if (out_en) begin
      if (m_burst > 0) begin
        e.data = SYNC_WORD; e.k = 2'b11; m_burst--;
      end else begin
        for (int i = 1; i <= NUM_CH; i++) begin
          c = (m_lg + i) % NUM_CH;
          if (!e.v && mq[c].size() > 0) begin
            e.v = 1'b1; e.k = 2'b00; e.data = mq[c].pop_front();
            m_lg = c; m_ch = c;
          end
        end
        m_run++;
        if (m_run == SYNC_PERIOD) begin m_run = 0; m_burst = SYNC_LEN; end
      end
    end
    e.ch = 2'(m_ch);
    if (clr_ovf) m_ovf = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (in_valid[i]) begin
        if (full[i]) m_ovf[i] = 1'b1;
        else mq[i].push_back(in_data[i*16 +: 16]);
      end
    for (int i = 0; i < NUM_CH; i++) e.rdy[i] = (mq[i].size() != DEPTH);
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the output registers against the prediction for this edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_on && exp_q.size() > 0 && exp_q[0].tag == cyc_n) begin
      e = exp_q.pop_front();
      check("tx_data",    32'(tx_data),    32'(e.data));
      check("tx_charisk", 32'(tx_charisk), 32'(e.k));
      check("tx_valid",   32'(tx_valid),   32'(e.v));
      check("tx_ch",      32'(tx_ch),      32'(e.ch));
      check("in_ready",   32'(in_ready),   32'(e.rdy));
      check("ovf",        32'(ovf),        32'(e.ovf));
    end
  end

  task automatic cyc(input logic oe, input logic [NUM_CH-1:0] v,
                     input logic [NUM_CH*DATA_W-1:0] d, input logic clr);
    out_en = oe; in_valid = v; in_data = d; clr_ovf = clr;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic oe);
    for (int i = 0; i < n; i++) cyc(oe, '0, '0, 1'b0);
  endtask

  task automatic rnd_cyc(input int vpct);
    logic [NUM_CH-1:0]        v;
    logic [NUM_CH*DATA_W-1:0] d;
    for (int c = 0; c < NUM_CH; c++) begin
      v[c] = ($urandom_range(0, 99) < vpct);
      d[c*16 +: 16] = 16'($urandom);
    end
    cyc($urandom_range(0, 19) != 0, v, d, $urandom_range(0, 49) == 0);
  endtask

  // Assert reset mid-cycle, check the outputs at once, then release reset.
  task automatic do_reset();
    mon_on = 1'b0; rst_n = 1'b0;
    out_en = 1'b0; in_valid = '0; clr_ovf = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check("rst tx_data",    32'(tx_data),    32'(IDLE_WORD));
    check("rst tx_charisk", 32'(tx_charisk), 32'(IDLE_K));
    check("rst tx_valid",   32'(tx_valid),   32'd0);
    check("rst tx_ch",      32'(tx_ch),      32'd0);
    check("rst in_ready",   32'(in_ready),   32'hF);
    check("rst ovf",        32'(ovf),        32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; mon_on = 1'b1;
  endtask

  initial begin
    logic [NUM_CH*DATA_W-1:0] d;
    @(posedge clk); #1;
    do_reset();
    // Initial burst, then idles.
    idle(20, 1'b1);
    // Two words written in the same cycle come out in channel order.
    d = '0; d[15:0] = 16'h1111; d[47:32] = 16'h2222;
    cyc(1'b1, 4'b0101, d, 1'b0);
    idle(4, 1'b1);
    // Keep every channel busy so the grant rotates 0,1,2,3.
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < NUM_CH; c++) d[c*16 +: 16] = 16'(i * 16 + c);
      cyc(1'b1, 4'b1111, d, 1'b0);
    end
    idle(70, 1'b1);
    cyc(1'b1, '0, '0, 1'b1);
    // Stall output and write 17 words to ch1, so the last one overflows.
    for (int i = 0; i < 17; i++) begin
      d = '0; d[31:16] = 16'hA000 + 16'(i);
      cyc(1'b0, 4'b0010, d, 1'b0);
    end
    idle(25, 1'b1);
    cyc(1'b1, '0, '0, 1'b1);
    idle(3, 1'b1);
    // Drop out_en partway through the initial burst.
    do_reset();
    idle(2, 1'b1); idle(10, 1'b0); idle(10, 1'b1);
    // Random traffic long enough to cover at least one periodic burst.
    for (int i = 0; i < 700; i++) rnd_cyc(10);
    for (int i = 0; i < 700; i++) rnd_cyc(35);
    // Asynchronous reset with words queued, an overflow and live output.
    for (int i = 0; i < 17; i++) begin
      d = '0; d[63:48] = 16'hC000 + 16'(i);
      cyc(1'b0, 4'b1000, d, 1'b0);
    end
    idle(1, 1'b1);
    do_reset();
    idle(20, 1'b1);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rd53_tx_frame_mux.md
Name: rd53_tx_frame_mux

Overview:
- Parametrised successor to the single-channel FIFO controller that feeds the GTX transmitter in the RD53 emulator top.
- Accepts NUM_CH independent word streams, each buffered in its own DEPTH-entry FIFO, and round-robin merges them onto one registered transmit word bus.
- Fills empty cycles with a comma idle word and inserts a periodic K-character sync burst for receiver alignment.
- Sits between the TTC/emulator data sources and the transceiver txdata/txcharisk inputs, in the txusrclk2 domain.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- NUM_CH, 4, number of input channels, 1..16.
- DEPTH, 16, per-channel FIFO depth; power of 2, at least 2.
- SYNC_PERIOD, 1024, output cycles between sync bursts, counted from the end of the previous burst; at least SYNC_LEN+1.
- SYNC_LEN, 4, words per sync burst, at least 1.
- IDLE_WORD, 16'h00BC, idle pattern; its charisk is IDLE_K.
- IDLE_K, 2'b01, charisk value for IDLE_WORD, DATA_W/8 bits.
- SYNC_WORD, 16'hBCBC, sync pattern; its charisk is all ones.

Ports:
- clk, in, 1, transmit user clock; sole clock of the block.
- rst_n, in, 1, asynchronous active-low reset.
- in_data, in, NUM_CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].
- in_valid, in, NUM_CH, per-channel write strobe.
- in_ready, out, NUM_CH, per-channel not-full indication.
- out_en, in, 1, downstream ready (GT reset done and MMCM locked).
- tx_data, out, DATA_W, registered word to the transceiver.
- tx_charisk, out, DATA_W/8, registered K-character flags.
- tx_valid, out, 1, high when tx_data carries a FIFO payload word.
- tx_ch, out, max(1,clog2(NUM_CH)), source channel of the current payload.
- ovf, out, NUM_CH, sticky per-channel overflow flags.
- clr_ovf, in, 1, synchronous clear of all ovf bits.

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 clears all FIFOs, pointers and counters at once.
- Reset output values: tx_data=IDLE_WORD, tx_charisk=IDLE_K, tx_valid=0, tx_ch=0, ovf=0, in_ready=all 1.
- Asserting reset mid-operation discards all buffered words with no partial output.
- FIFO write:
  - in_ready[c] = (count[c] != DEPTH), combinational from registered count.
  - A word is written when in_valid[c] & in_ready[c].
  - If in_valid[c] is high while the FIFO is full, the word is dropped and ovf[c] is set.
  - A full FIFO does not accept a write in the same cycle it is read (no full bypass).
- ovf: set takes priority over clr_ovf in the same cycle.
- FSM states: INIT_SYNC, RUN, SYNC.
  - After reset the FSM enters INIT_SYNC, which emits SYNC_LEN SYNC_WORD cycles and then goes to RUN.
  - In RUN, sync_cnt increments each out_en cycle. The cycle after sync_cnt reaches SYNC_PERIOD-1, the FSM enters SYNC, emits SYNC_LEN SYNC_WORD cycles, returns to RUN and clears sync_cnt.
  - Sync words carry tx_charisk=all ones and tx_valid=0. No FIFO is popped during INIT_SYNC or SYNC.
- RUN arbitration:
  - The grant goes to the first non-empty channel after last_grant, searching cyclically (last_grant resets to NUM_CH-1, so channel 0 has first priority).
  - The granted head word is popped and registered to tx_data with tx_charisk=0, tx_valid=1 and tx_ch=granted index; last_grant is updated.
  - If every FIFO is empty, the output is IDLE_WORD/IDLE_K with tx_valid=0, and tx_ch holds its previous value.
- Latency: a word written at edge k can appear on tx_data at edge k+1 at the earliest, with one word per cycle maximum.
- out_en=0: output is forced to IDLE_WORD/IDLE_K with tx_valid=0. Nothing is popped, the FSM state and sync_cnt/burst counters freeze, and FIFO writes continue. When out_en returns, the FSM resumes exactly where it stopped, including any partially emitted burst.
- Simultaneous read and write on a non-full FIFO: count is unchanged and data order is preserved.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then hold out_en=1 with no input: 4 cycles of tx_data=16'hBCBC/charisk 2'b11, then 16'h00BC/2'b01 with tx_valid=0. A second burst starts exactly 1024 RUN cycles later.
- After the sync burst, write 0x1111 to ch0 and 0x2222 to ch2 in the same cycle: next two output cycles are 0x1111 (tx_ch=0), then 0x2222 (tx_ch=2), both tx_valid=1, charisk=0.
- Keep all 4 channels non-empty continuously: tx_ch sequence is 0,1,2,3,0,... with no idle gaps except sync bursts.
- Hold out_en=0, write 17 words to ch1: in_ready[1]=0 after the 16th write, the 17th is dropped and ovf[1]=1. Release out_en: exactly 16 words emerge in order. Pulse clr_ovf: ovf=0.
- Drop out_en for 10 cycles midway through a sync burst (after 2 words): on release, 2 more sync words are emitted, then RUN resumes.
- Assert rst_n=0 asynchronously with 5 words queued: outputs go to reset values immediately; after release only the INIT_SYNC burst and idles appear, with no stale data.
